// File: rtl/ifetch_buffer_if.sv
// Fetch-side bundle: I-cache request/response, redirect strobe and decode-side buffer head.
// Latency: pure wiring, adds none.
// Backpressure: request and head pop are valid/ready; responses and redirects cannot be stalled.
interface ifetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            redir_i;
    logic [XLEN-1:0] redir_pc_i;

    logic            ic_req_valid_o;
    logic            ic_req_ready_i;
    logic [XLEN-1:0] ic_req_addr_o;

    logic            ic_rsp_valid_i;
    logic [XLEN-1:0] ic_rsp_data_i;

    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;

    logic            err_o;

    // Fetch unit side
    modport master (
        input  redir_i,
        input  redir_pc_i,
        output ic_req_valid_o,
        input  ic_req_ready_i,
        output ic_req_addr_o,
        input  ic_rsp_valid_i,
        input  ic_rsp_data_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_o,
        output inst_pc_o,
        output err_o
    );

    // Environment side (I-cache, decode, redirect source)
    modport slave (
        output redir_i,
        output redir_pc_i,
        input  ic_req_valid_o,
        output ic_req_ready_i,
        input  ic_req_addr_o,
        output ic_rsp_valid_i,
        output ic_rsp_data_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_o,
        input  inst_pc_o,
        input  err_o
    );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues sequential I-cache requests and queues returned words for decode.
// Latency: a response is written at the edge and appears at the buffer head the next cycle (no bypass).
// Backpressure: requests are credit-gated (buffer slots + in-flight + pending drops); decode stalls via inst_ready_i.
module ifetch_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ifetch_buffer_if.master bus
);
    // Pointer, occupancy and credit-sum widths. The sum width holds occ + outst + drop_cnt,
    // which is bounded by 2*DEPTH because outst + drop_cnt never exceeds MAX_OUTST <= DEPTH.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] sum_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    // Architectural state
    logic [XLEN-1:0] fpc;        // next address to request
    logic [XLEN-1:0] rpc;        // PC belonging to the next live response
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    ptr_t            head;
    ptr_t            tail;
    cnt_t            occ;        // buffered entries
    cnt_t            outst;      // live requests in flight
    cnt_t            drop_cnt;   // stale requests in flight whose responses must be discarded
    logic            err;

    // Per-cycle decode of the inputs against current state
    logic            redir;
    logic            rsp;
    sum_t            pending;    // every request still owed a response, live or stale
    sum_t            committed;  // buffer slots already promised
    logic            req_vld;
    logic            req_fire;
    logic            inst_vld;
    logic            pop;
    logic            rsp_owned;  // response matches some request in flight
    logic            rsp_drop;   // response belongs to a request issued before a redirect
    logic            push;       // response is live and gets written at the tail
    logic            rsp_stray;  // response with nothing in flight at all
    sum_t            drop_after;
    cnt_t            drop_redir;

    assign redir     = bus.redir_i;
    assign rsp       = bus.ic_rsp_valid_i;

    assign pending   = sum_t'(outst) + sum_t'(drop_cnt);
    assign committed = sum_t'(occ) + pending;

    // Credit rule: in-flight cap, and a guaranteed slot for every response that could be live.
    // Gated by rst_i so the request line stays low for the whole reset window.
    assign req_vld   = !rst_i && !redir
                     && (pending   < sum_t'(MAX_OUTST))
                     && (committed < sum_t'(DEPTH));
    assign req_fire  = req_vld && bus.ic_req_ready_i;

    assign inst_vld  = (occ != '0);
    assign pop       = inst_vld && bus.inst_ready_i && !redir;

    // Responses come back in request order, so stale ones (drop_cnt) are always ahead of live ones.
    assign rsp_owned = rsp && (pending != '0);
    assign rsp_drop  = rsp && (drop_cnt != '0);
    assign push      = rsp && (drop_cnt == '0) && (outst != '0) && !redir;
    assign rsp_stray = rsp && (pending == '0);

    // On a redirect every request still in flight becomes stale, minus the one answered this cycle.
    assign drop_after = pending - sum_t'(rsp_owned);
    assign drop_redir = cnt_t'(drop_after);

    // Outputs toward I-cache and decode
    assign bus.ic_req_valid_o = req_vld;
    assign bus.ic_req_addr_o  = fpc;
    assign bus.inst_valid_o   = inst_vld;
    assign bus.inst_o         = inst_vld ? inst_mem[head] : '0;
    assign bus.inst_pc_o      = inst_vld ? pc_mem[head]   : '0;
    assign bus.err_o          = err;

    // Fetch/response PCs, pointers and credit counters; redirect flushes everything and re-aims both PCs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            outst    <= '0;
            drop_cnt <= '0;
        end else if (redir) begin
            fpc      <= bus.redir_pc_i;
            rpc      <= bus.redir_pc_i;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            outst    <= '0;
            drop_cnt <= drop_redir;
        end else begin
            if (req_fire) begin
                fpc <= fpc + STEP;
            end
            if (push) begin
                tail <= tail + ptr_t'(1);
                rpc  <= rpc + STEP;
            end
            if (pop) begin
                head <= head + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
            occ   <= occ + cnt_t'(push) - cnt_t'(pop);
            outst <= outst + cnt_t'(req_fire) - cnt_t'(push);
        end
    end

    // Sticky protocol error: a response arrived that no request can account for.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (rsp_stray) begin
            err <= 1'b1;
        end
    end

    // Entry storage written at the tail; reads are masked by occ so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem[tail] <= bus.ic_rsp_data_i;
            pc_mem[tail]   <= rpc;
        end
    end

    // A live response must always find a free slot unless the head leaves in the same cycle.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && (occ == cnt_t'(DEPTH))));

    // Live plus stale requests can never exceed the in-flight cap.
    assert property (@(posedge clk_i) disable iff (rst_i) (pending <= sum_t'(MAX_OUTST)));

endmodule
